// File: rtl/dlx_pipe_pkg.sv
// Shared types and default widths for the DLX pipeline registers.
package dlx_pipe_pkg;

  localparam int unsigned DEF_XLEN   = 32;
  localparam int unsigned DEF_RA_W   = 5;
  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_PERF_W = 16;

  // Payload of the ID/EX register; valid is tracked separately.
  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic                  is_load;
    logic [DEF_RA_W-1:0]   rd;
    logic [DEF_XLEN-1:0]   imm;
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_XLEN-1:0]   s1;
    logic [DEF_XLEN-1:0]   s2;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUBBLE = '0;

endpackage : dlx_pipe_pkg

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding select: EX > MEM > WB > register file, r0 reads zero.
module fwd_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data_c
);

  always_comb begin
    data_c = rf_data;
    if (rs == '0) begin
      data_c = '0;
    end else if (ex_valid && (ex_rd == rs)) begin
      data_c = ex_data;
    end else if (mem_valid && (mem_rd == rs)) begin
      data_c = mem_data;
    end else if (wb_valid && (wb_rd == rs)) begin
      data_c = wb_data;
    end
  end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use interlock,
// branch flush, downstream hold and a saturating stall counter.
module id_ex_stage
  import dlx_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned RA_W   = DEF_RA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned PERF_W = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_is_load_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   rf_s1_i,
  input  logic [XLEN-1:0]   rf_s2_i,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  input  logic              ex_fwd_valid_i,
  input  logic [RA_W-1:0]   ex_fwd_rd_i,
  input  logic [XLEN-1:0]   ex_fwd_data_i,
  input  logic              mem_fwd_valid_i,
  input  logic [RA_W-1:0]   mem_fwd_rd_i,
  input  logic [XLEN-1:0]   mem_fwd_data_i,
  input  logic              wb_fwd_valid_i,
  input  logic [RA_W-1:0]   wb_fwd_rd_i,
  input  logic [XLEN-1:0]   wb_fwd_data_i,
  output logic              id_stall_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              ex_is_load_o,
  output logic [RA_W-1:0]   ex_rd_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_s1_o,
  output logic [XLEN-1:0]   ex_s2_o,
  output logic [PERF_W-1:0] stall_count_o
);

  localparam logic [PERF_W-1:0] CNT_MAX = '1;

  ex_bundle_t        ex_q;
  logic              valid_q;
  logic [PERF_W-1:0] stall_cnt_q;

  logic [XLEN-1:0] s1_fwd_c;
  logic [XLEN-1:0] s2_fwd_c;
  logic            luh_c;
  logic            bubble_c;
  logic            cnt_inc_c;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_s1 (
    .rs        (id_rs1_i),
    .rf_data   (rf_s1_i),
    .ex_valid  (ex_fwd_valid_i),
    .ex_rd     (ex_fwd_rd_i),
    .ex_data   (ex_fwd_data_i),
    .mem_valid (mem_fwd_valid_i),
    .mem_rd    (mem_fwd_rd_i),
    .mem_data  (mem_fwd_data_i),
    .wb_valid  (wb_fwd_valid_i),
    .wb_rd     (wb_fwd_rd_i),
    .wb_data   (wb_fwd_data_i),
    .data_c    (s1_fwd_c)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_s2 (
    .rs        (id_rs2_i),
    .rf_data   (rf_s2_i),
    .ex_valid  (ex_fwd_valid_i),
    .ex_rd     (ex_fwd_rd_i),
    .ex_data   (ex_fwd_data_i),
    .mem_valid (mem_fwd_valid_i),
    .mem_rd    (mem_fwd_rd_i),
    .mem_data  (mem_fwd_data_i),
    .wb_valid  (wb_fwd_valid_i),
    .wb_rd     (wb_fwd_rd_i),
    .wb_data   (wb_fwd_data_i),
    .data_c    (s2_fwd_c)
  );

  // A load still in EX cannot forward; any consumer in ID must wait a cycle.
  always_comb begin
    luh_c = id_valid_i && valid_q && ex_q.is_load && (ex_q.rd != '0) &&
            ((id_rs1_used_i && (id_rs1_i == ex_q.rd)) ||
             (id_rs2_used_i && (id_rs2_i == ex_q.rd)));
    bubble_c  = flush_i || luh_c || !id_valid_i;
    cnt_inc_c = luh_c && !flush_i && !ex_stall_i;
  end

  assign id_stall_o = ex_stall_i || (luh_c && !flush_i);

  // Hold wins over flush; the flush is re-presented once the hold releases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ex_q    <= EX_BUBBLE;
    end else if (!ex_stall_i) begin
      if (bubble_c) begin
        valid_q <= 1'b0;
        ex_q    <= EX_BUBBLE;
      end else begin
        valid_q    <= 1'b1;
        ex_q.ctrl    <= id_ctrl_i;
        ex_q.is_load <= id_is_load_i;
        ex_q.rd      <= id_rd_i;
        ex_q.imm     <= id_imm_i;
        ex_q.pc      <= id_pc_i;
        ex_q.s1      <= s1_fwd_c;
        ex_q.s2      <= s2_fwd_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (cnt_inc_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_ctrl_o     = ex_q.ctrl;
  assign ex_is_load_o  = ex_q.is_load;
  assign ex_rd_o       = ex_q.rd;
  assign ex_imm_o      = ex_q.imm;
  assign ex_pc_o       = ex_q.pc;
  assign ex_s1_o       = ex_q.s1;
  assign ex_s2_o       = ex_q.s2;
  assign stall_count_o = stall_cnt_q;

endmodule : id_ex_stage
